bridge_rom_reader: RTL

Bridge read-side responder for the ROM/cram address window: the read counterpart of the existing bridge-to-cram write path. It serves host bridge reads by fetching two 16-bit halfwords from a req/ack memory port and assembling a 32-bit word. It speculatively prefetches the next sequential word, so streamed reads such as save/dataslot readback return with minimum latency. It sits between one bridge_master leaf output and a cram arbiter read port.

---
 rtl/bridge_rom_reader.sv | 279 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/bridge_rom_reader.sv
// -----------------------------------------------------------------------------
// bridge_rom_reader
//
// Read-side responder for the ROM/cram bridge window. A bridge read is served
// by fetching two 16-bit halfwords over a req/ack memory port and assembling
// them into one 32-bit word. After every delivered word the next sequential
// word is prefetched into a one-entry buffer, so streamed readback hits the
// buffer and returns one cycle after the strobe.
//
// Ports:
//   clk             bridge clock
//   reset           synchronous, active-high
//   bridge_addr     byte address of the read (bits [1:0] ignored)
//   bridge_rd       single-cycle read strobe
//   bridge_rd_data  assembled word, held between deliveries
//   bridge_rd_valid one-cycle pulse when bridge_rd_data answers the newest read
//   busy            high while a memory transaction is outstanding
//   mem_rd_req      memory read request, held until mem_ack
//   mem_addr        halfword address presented with mem_rd_req
//   mem_ack         request accepted (one cycle)
//   mem_rd_data     halfword read data
//   mem_rd_valid    one-cycle data strobe, at or after mem_ack
// -----------------------------------------------------------------------------
module bridge_rom_reader #(
    parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
    parameter int          ADDR_SPAN_LOG2 = 20,
    parameter int          MEM_ADDR_W     = 21,
    parameter bit          ENDIAN_LITTLE  = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           bridge_addr,
    input  logic                  bridge_rd,
    output logic [31:0]           bridge_rd_data,
    output logic                  bridge_rd_valid,
    output logic                  busy,
    output logic                  mem_rd_req,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [15:0]           mem_rd_data,
    input  logic                  mem_rd_valid
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ_A   = 3'd1,
        WAIT_A  = 3'd2,
        REQ_B   = 3'd3,
        WAIT_B  = 3'd4,
        DELIVER = 3'd5
    } state_t;

    localparam logic [31:0] WINDOW_BYTES = 32'(1) << ADDR_SPAN_LOG2;

    // All addresses below are word-aligned offsets into the window.
    state_t                state_q,      state_d;
    logic [31:0]           cur_addr_q,   cur_addr_d;
    logic                  cur_demand_q, cur_demand_d;
    logic [15:0]           hw_a_q,       hw_a_d;
    logic [15:0]           hw_b_q,       hw_b_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [31:0]           pend_addr_q,  pend_addr_d;
    logic                  pf_valid_q,   pf_valid_d;
    logic [31:0]           pf_tag_q,     pf_tag_d;
    logic [31:0]           pf_data_q,    pf_data_d;
    logic [31:0]           rd_data_q,    rd_data_d;
    logic                  rd_valid_q,   rd_valid_d;

    logic [31:0]           in_off;
    logic [31:0]           in_word;
    logic [31:0]           in_next;
    logic [31:0]           cur_next;
    logic                  in_window;
    logic                  rd_accept;
    logic                  in_next_ok;
    logic                  cur_next_ok;
    logic                  pf_hit;
    logic                  eff_pend_valid;
    logic [31:0]           eff_pend_addr;
    logic [31:0]           word_asm;
    logic [MEM_ADDR_W-1:0] cur_hw;

    // ---------------------------------------------------------------------
    // Address decode
    // ---------------------------------------------------------------------
    assign in_off      = bridge_addr - ADDR_BASE;
    assign in_word     = {in_off[31:2], 2'b00};
    assign in_window   = (in_off < WINDOW_BYTES);
    assign rd_accept   = bridge_rd && in_window;
    assign in_next     = in_word + 32'd4;
    assign in_next_ok  = (in_next < WINDOW_BYTES);
    assign cur_next    = cur_addr_q + 32'd4;
    assign cur_next_ok = (cur_next < WINDOW_BYTES);
    assign pf_hit      = pf_valid_q && (pf_tag_q == in_word);
    assign cur_hw      = MEM_ADDR_W'(cur_addr_q >> 1);

    // A strobe landing in the DELIVER cycle is the newest read and must be
    // weighed against the in-flight result just like a latched one.
    assign eff_pend_valid = pend_valid_q || rd_accept;
    assign eff_pend_addr  = rd_accept ? in_word : pend_addr_q;

    generate
        if (ENDIAN_LITTLE) begin : g_word_le
            assign word_asm = {hw_b_q, hw_a_q};
        end else begin : g_word_be
            assign word_asm = {hw_a_q, hw_b_q};
        end
    endgenerate

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cur_addr_q   <= '0;
            cur_demand_q <= 1'b0;
            hw_a_q       <= '0;
            hw_b_q       <= '0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pf_valid_q   <= 1'b0;
            pf_tag_q     <= '0;
            pf_data_q    <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            cur_demand_q <= cur_demand_d;
            hw_a_q       <= hw_a_d;
            hw_b_q       <= hw_b_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            pf_valid_q   <= pf_valid_d;
            pf_tag_q     <= pf_tag_d;
            pf_data_q    <= pf_data_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        cur_demand_d = cur_demand_q;
        hw_a_d       = hw_a_q;
        hw_b_d       = hw_b_q;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        pf_valid_d   = pf_valid_q;
        pf_tag_d     = pf_tag_q;
        pf_data_d    = pf_data_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = 1'b0;

        // While a fetch is in flight, reads only update the one-deep slot;
        // the newest one wins.
        if (rd_accept && (state_q != IDLE) && (state_q != DELIVER)) begin
            pend_valid_d = 1'b1;
            pend_addr_d  = in_word;
        end

        case (state_q)
            IDLE: begin
                pend_valid_d = 1'b0;
                if (rd_accept) begin
                    // The buffer is consumed by a hit and dropped on a miss.
                    pf_valid_d = 1'b0;
                    if (pf_hit) begin
                        rd_data_d  = pf_data_q;
                        rd_valid_d = 1'b1;
                        if (in_next_ok) begin
                            state_d      = REQ_A;
                            cur_addr_d   = in_next;
                            cur_demand_d = 1'b0;
                        end
                    end else begin
                        state_d      = REQ_A;
                        cur_addr_d   = in_word;
                        cur_demand_d = 1'b1;
                    end
                end
            end

            REQ_A: begin
                if (mem_ack) begin
                    if (mem_rd_valid) begin
                        hw_a_d  = mem_rd_data;
                        state_d = REQ_B;
                    end else begin
                        state_d = WAIT_A;
                    end
                end
            end

            WAIT_A: begin
                if (mem_rd_valid) begin
                    hw_a_d  = mem_rd_data;
                    state_d = REQ_B;
                end
            end

            REQ_B: begin
                if (mem_ack) begin
                    if (mem_rd_valid) begin
                        hw_b_d  = mem_rd_data;
                        state_d = DELIVER;
                    end else begin
                        state_d = WAIT_B;
                    end
                end
            end

            WAIT_B: begin
                if (mem_rd_valid) begin
                    hw_b_d  = mem_rd_data;
                    state_d = DELIVER;
                end
            end

            DELIVER: begin
                pend_valid_d = 1'b0;
                if ((eff_pend_valid && (eff_pend_addr == cur_addr_q)) ||
                    (!eff_pend_valid && cur_demand_q)) begin
                    // Either a demand fetch, or a fetch (possibly a prefetch)
                    // that the newest read asked for: hand it to the bridge
                    // and chain a prefetch of the following word.
                    rd_data_d  = word_asm;
                    rd_valid_d = 1'b1;
                    if (cur_next_ok) begin
                        state_d      = REQ_A;
                        cur_addr_d   = cur_next;
                        cur_demand_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (eff_pend_valid) begin
                    // The newest read wants a different word: drop this one.
                    state_d      = REQ_A;
                    cur_addr_d   = eff_pend_addr;
                    cur_demand_d = 1'b1;
                end else begin
                    pf_valid_d = 1'b1;
                    pf_tag_d   = cur_addr_q;
                    pf_data_d  = word_asm;
                    state_d    = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    always_comb begin
        mem_rd_req = 1'b0;
        mem_addr   = '0;
        if (state_q == REQ_A) begin
            mem_rd_req = 1'b1;
            mem_addr   = cur_hw;
        end else if (state_q == REQ_B) begin
            mem_rd_req = 1'b1;
            mem_addr   = cur_hw + MEM_ADDR_W'(1);
        end
    end

    assign busy            = (state_q != IDLE);
    assign bridge_rd_data  = rd_data_q;
    assign bridge_rd_valid = rd_valid_q;

endmodule
